// File: rtl/expr_calculator_if.sv
// Operand/result handshake bundle between the digit classifier, the calculator
// and the display driver.
interface expr_calculator_if;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] shape_1;
   logic [3:0] shape_2;
   logic [1:0] shape_sym;
   logic       out_valid;
   logic       out_ready;
   logic       res_neg;
   logic [3:0] res_tens;
   logic [3:0] res_ones;
   logic [3:0] res_rem;
   logic       div_err;
   logic       range_err;

   modport master (
      output in_valid, shape_1, shape_2, shape_sym, out_ready,
      input  in_ready, out_valid, res_neg, res_tens, res_ones, res_rem,
             div_err, range_err
   );

   modport slave (
      input  in_valid, shape_1, shape_2, shape_sym, out_ready,
      output in_ready, out_valid, res_neg, res_tens, res_ones, res_rem,
             div_err, range_err
   );
endinterface

// File: rtl/expr_calculator.sv
// Two-digit calculator: iterative add/sub/mul/div on 0-9 operands, followed by
// a double-dabble conversion of |result| to two BCD digits.
module expr_calculator #(
   parameter logic [1:0] OP_ADD  = 2'b00,
   parameter logic [1:0] OP_SUB  = 2'b01,
   parameter logic [1:0] OP_MUL  = 2'b10,
   parameter logic [1:0] OP_DIV  = 2'b11,
   parameter logic [3:0] DIG_MAX = 4'd9
) (
   input logic              clk,
   input logic              rst,
   expr_calculator_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_BCD, S_DONE} state_e;

   state_e     state_q, state_d;
   logic [3:0] a_q, a_d, b_q, b_d;
   logic [1:0] op_q, op_d;
   logic [2:0] cnt_q, cnt_d;
   logic [6:0] acc_q, acc_d;
   logic [3:0] prem_q, prem_d;
   logic [7:0] bcd_q, bcd_d;
   logic       neg_w_q, neg_w_d;
   logic       neg_q, neg_d;
   logic [3:0] tens_q, tens_d, ones_q, ones_d, rem_q, rem_d;
   logic       div_err_q, div_err_d, range_err_q, range_err_d;

   logic        range_bad, div_zero, any_err, fast_op;
   logic [4:0]  div_trial;
   logic [7:0]  bcd_adj;
   logic [14:0] dd_shift;

   function automatic logic [3:0] adj3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   assign range_bad = (a_q > DIG_MAX) || (b_q > DIG_MAX);
   assign div_zero  = (op_q == OP_DIV) && (b_q == 4'd0) && !range_bad;
   assign any_err   = range_bad || div_zero;
   assign fast_op   = (op_q == OP_ADD) || (op_q == OP_SUB);
   // acc_q[3:0] holds the dividend during DIV; quotient bits shift in from the right.
   assign div_trial = {prem_q, acc_q[3]};
   assign bcd_adj   = {adj3(bcd_q[7:4]), adj3(bcd_q[3:0])};
   assign dd_shift  = {bcd_adj, acc_q} << 1;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      prem_d      = prem_q;
      bcd_d       = bcd_q;
      neg_w_d     = neg_w_q;
      neg_d       = neg_q;
      tens_d      = tens_q;
      ones_d      = ones_q;
      rem_d       = rem_q;
      div_err_d   = div_err_q;
      range_err_d = range_err_q;

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_d         = bus.shape_1;
               b_d         = bus.shape_2;
               op_d        = bus.shape_sym;
               cnt_d       = 3'd0;
               acc_d       = (bus.shape_sym == OP_DIV) ? {3'b000, bus.shape_1} : 7'd0;
               prem_d      = 4'd0;
               neg_w_d     = 1'b0;
               div_err_d   = 1'b0;
               range_err_d = 1'b0;
               state_d     = S_CALC;
            end
         end
         S_CALC: begin
            if (op_q == OP_ADD) begin
               acc_d = {3'b000, a_q} + {3'b000, b_q};
            end else if (op_q == OP_SUB) begin
               neg_w_d = (a_q < b_q);
               acc_d   = (a_q < b_q) ? {3'b000, b_q - a_q} : {3'b000, a_q - b_q};
            end else if (op_q == OP_MUL) begin
               acc_d = acc_q + (b_q[cnt_q[1:0]] ? ({3'b000, a_q} << cnt_q[1:0]) : 7'd0);
            end else if (div_trial >= {1'b0, b_q}) begin
               prem_d = div_trial[3:0] - b_q;
               acc_d  = {3'b000, acc_q[2:0], 1'b1};
            end else begin
               prem_d = div_trial[3:0];
               acc_d  = {3'b000, acc_q[2:0], 1'b0};
            end
            cnt_d = cnt_q + 3'd1;
            if (fast_op || (cnt_q == 3'd3)) begin
               cnt_d   = 3'd0;
               bcd_d   = 8'd0;
               state_d = S_BCD;
            end
         end
         S_BCD: begin
            acc_d = dd_shift[6:0];
            bcd_d = dd_shift[14:7];
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd6) begin
               tens_d      = any_err ? 4'd0 : dd_shift[14:11];
               ones_d      = any_err ? 4'd0 : dd_shift[10:7];
               rem_d       = (!any_err && (op_q == OP_DIV)) ? prem_q : 4'd0;
               neg_d       = neg_w_q && !range_bad;
               div_err_d   = div_zero;
               range_err_d = range_bad;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         prem_q      <= '0;
         bcd_q       <= '0;
         neg_w_q     <= 1'b0;
         neg_q       <= 1'b0;
         tens_q      <= '0;
         ones_q      <= '0;
         rem_q       <= '0;
         div_err_q   <= 1'b0;
         range_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         prem_q      <= prem_d;
         bcd_q       <= bcd_d;
         neg_w_q     <= neg_w_d;
         neg_q       <= neg_d;
         tens_q      <= tens_d;
         ones_q      <= ones_d;
         rem_q       <= rem_d;
         div_err_q   <= div_err_d;
         range_err_q <= range_err_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.res_neg   = neg_q;
   assign bus.res_tens  = tens_q;
   assign bus.res_ones  = ones_q;
   assign bus.res_rem   = rem_q;
   assign bus.div_err   = div_err_q;
   assign bus.range_err = range_err_q;
endmodule

// File: tb/tb_expr_calculator.sv
// Bench for expr_calculator: directed vector table, mid-operation reset and
// randomized operations against an arithmetic reference model.
module tb_expr_calculator;
   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   expr_calculator_if bus ();

   expr_calculator dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       neg;
      logic [3:0] tens;
      logic [3:0] ones;
      logic [3:0] rem;
      logic       derr;
      logic       rerr;
      int         lat;
   } exp_t;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [1:0] op;
      exp_t       e;
      int         hold;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
      end
   endtask

   function automatic logic [16:0] obs();
      return {bus.res_neg, bus.res_tens, bus.res_ones, bus.res_rem,
              bus.div_err, bus.range_err, bus.out_valid, bus.in_ready};
   endfunction

   function automatic logic [16:0] want(input exp_t e, input logic ov, input logic ir);
      return {e.neg, e.tens, e.ones, e.rem, e.derr, e.rerr, ov, ir};
   endfunction

   // Reference: plain integer arithmetic straight from the operator definitions.
   function automatic exp_t model(input int a, input int b, input int op);
      exp_t e;
      int   r;
      e = '{neg: 1'b0, tens: 4'd0, ones: 4'd0, rem: 4'd0, derr: 1'b0, rerr: 1'b0, lat: 0};
      r = 0;
      e.lat = (op >= 2) ? 11 : 8;
      if (a > 9 || b > 9) begin
         e.rerr = 1'b1;
      end else begin
         case (op)
            0: r = a + b;
            1: begin
               r     = (a >= b) ? a - b : b - a;
               e.neg = (a < b);
            end
            2: r = a * b;
            default: begin
               if (b == 0) e.derr = 1'b1;
               else begin
                  r     = a / b;
                  e.rem = 4'(a % b);
               end
            end
         endcase
      end
      e.tens = 4'(r / 10);
      e.ones = 4'(r % 10);
      return e;
   endfunction

   function automatic vec_t mkv(input int a, input int b, input int op, input int neg,
                                input int tens, input int ones, input int rem,
                                input int derr, input int rerr, input int lat, input int hold);
      vec_t v;
      v.a      = 4'(a);
      v.b      = 4'(b);
      v.op     = 2'(op);
      v.e.neg  = 1'(neg);
      v.e.tens = 4'(tens);
      v.e.ones = 4'(ones);
      v.e.rem  = 4'(rem);
      v.e.derr = 1'(derr);
      v.e.rerr = 1'(rerr);
      v.e.lat  = lat;
      v.hold   = hold;
      return v;
   endfunction

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                        input exp_t e, input int hold, input string tag);
      int lat  = 0;
      bit seen = 1'b0;
      check({tag, " ready_before"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid  = 1'b1;
      bus.shape_1   = a;
      bus.shape_2   = b;
      bus.shape_sym = op;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      while (!seen && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (lat == 1) check({tag, " flags_clear"}, 32'({bus.div_err, bus.range_err}), 32'd0);
         if (bus.out_valid) seen = 1'b1;
         else begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.shape_1   = 4'($urandom);
            bus.shape_2   = 4'($urandom);
            bus.shape_sym = 2'($urandom);
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check({tag, " latency"}, 32'(lat), 32'(e.lat));
      check({tag, " result"}, 32'(obs()), 32'(want(e, 1'b1, 1'b0)));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         check({tag, " hold"}, 32'(obs()), 32'(want(e, 1'b1, 1'b0)));
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      @(negedge clk);
      check({tag, " release"}, 32'(obs()), 32'(want(e, 1'b0, 1'b1)));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs [12];
      exp_t e_zero;
      int   ra, rb, rop;

      e_zero = '{neg: 1'b0, tens: 4'd0, ones: 4'd0, rem: 4'd0, derr: 1'b0, rerr: 1'b0, lat: 0};
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.shape_1   = '0;
      bus.shape_2   = '0;
      bus.shape_sym = '0;
      rst           = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_state", 32'(obs()), 32'(want(e_zero, 1'b0, 1'b1)));
      rst = 1'b0;

      //           a   b  op neg tens ones rem derr rerr lat hold
      vecs[0]  = mkv(7,  8, 0, 0,  1,   5,   0,  0,   0,   8,  0);
      vecs[1]  = mkv(3,  9, 1, 1,  0,   6,   0,  0,   0,   8,  0);
      vecs[2]  = mkv(9,  3, 1, 0,  0,   6,   0,  0,   0,   8,  0);
      vecs[3]  = mkv(9,  9, 2, 0,  8,   1,   0,  0,   0,  11,  5);
      vecs[4]  = mkv(0,  7, 2, 0,  0,   0,   0,  0,   0,  11,  0);
      vecs[5]  = mkv(7,  2, 3, 0,  0,   3,   1,  0,   0,  11,  0);
      vecs[6]  = mkv(9,  9, 3, 0,  0,   1,   0,  0,   0,  11,  0);
      vecs[7]  = mkv(5,  0, 3, 0,  0,   0,   0,  1,   0,  11,  0);
      vecs[8]  = mkv(12, 3, 0, 0,  0,   0,   0,  0,   1,   8,  0);
      vecs[9]  = mkv(12, 0, 3, 0,  0,   0,   0,  0,   1,  11,  0);
      vecs[10] = mkv(2, 15, 1, 0,  0,   0,   0,  0,   1,   8,  0);
      vecs[11] = mkv(9,  9, 0, 0,  1,   8,   0,  0,   0,   8,  2);

      for (int i = 0; i < 12; i++)
         do_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].e, vecs[i].hold, $sformatf("vec%0d", i));

      // Reset during the second CALC cycle of a multiply must clear everything at once.
      bus.in_valid  = 1'b1;
      bus.shape_1   = 4'd9;
      bus.shape_2   = 4'd9;
      bus.shape_sym = 2'b10;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      #1 check("mid_reset", 32'(obs()), 32'(want(e_zero, 1'b0, 1'b1)));
      @(negedge clk);
      rst = 1'b0;
      do_op(4'd12, 4'd3, 2'b00, model(12, 3, 0), 0, "range_after_reset");

      for (int i = 0; i < 40; i++) begin
         ra  = $urandom_range(0, 11);
         rb  = $urandom_range(0, 11);
         rop = $urandom_range(0, 3);
         do_op(4'(ra), 4'(rb), 2'(rop), model(ra, rb, rop), $urandom_range(0, 3),
               $sformatf("rand%0d op%0d %0d,%0d", i, rop, ra, rb));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
